// File: rtl/bit_align_pkg.sv
// Shared state encoding, defaults and counter-width helper for the bit-alignment framer.
package bit_align_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } align_state_e;

  localparam int          DEF_WORD_W = 12;
  localparam logic [11:0] DEF_TP     = 12'hA5B;

  // Width needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_LOCK_CNT_W = cnt_width(4);
  localparam int DEF_LOSS_CNT_W = cnt_width(2);
  localparam int DEF_BIT_CNT_W  = $clog2(DEF_WORD_W);

endpackage

// File: rtl/align_pattern_det.sv
// Sliding serial window: exposes the window including the bit arriving this cycle and
// flags when that window equals the training pattern, at any bit offset.
module align_pattern_det
  import bit_align_pkg::*;
#(
  parameter int                WORD_W = DEF_WORD_W,
  parameter logic [WORD_W-1:0] TP     = DEF_TP
) (
  input  logic              CLK_IN,
  input  logic              Test_N,
  input  logic              serial_data,
  output logic [WORD_W-1:0] sr_next,
  output logic              match
);

  logic [WORD_W-1:0] sr_r;

  assign sr_next = {serial_data, sr_r[WORD_W-1:1]};
  assign match   = (sr_next == TP);

  always_ff @(posedge CLK_IN or negedge Test_N) begin
    if (!Test_N) begin
      sr_r <= '0;
    end else begin
      sr_r <= sr_next;
    end
  end

endmodule

// File: rtl/bit_align_framer.sv
// Word framer: searches for the training pattern, confirms it on successive word
// boundaries, then deserialises words and watches for lock loss while training.
module bit_align_framer
  import bit_align_pkg::*;
#(
  parameter int                WORD_W   = DEF_WORD_W,
  parameter logic [WORD_W-1:0] TP       = DEF_TP,
  parameter int                LOCK_CNT = 4,
  parameter int                LOSS_CNT = 2,
  parameter int                CNT_W    = 8
) (
  input  logic              CLK_IN,
  input  logic              Test_N,
  input  logic              serial_data,
  input  logic              train_en,
  input  logic              retrain,
  output logic [WORD_W-1:0] data_word,
  output logic              word_valid,
  output logic              SDR_CLK,
  output logic              locked,
  output logic [CNT_W-1:0]  realign_cnt
);

  localparam int MC_W = cnt_width(LOCK_CNT);
  localparam int EC_W = cnt_width(LOSS_CNT);
  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WORD_W - 1);
  localparam logic [BC_W-1:0] BIT_HALF = BC_W'(WORD_W / 2 - 1);
  localparam logic [MC_W-1:0] LOCK_LIM = MC_W'(LOCK_CNT);
  localparam logic [EC_W-1:0] LOSS_LIM = EC_W'(LOSS_CNT);

  align_state_e      state_r, state_s;
  logic [BC_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic [MC_W-1:0]   match_cnt_r, match_cnt_s;
  logic [EC_W-1:0]   err_cnt_r, err_cnt_s;
  logic [CNT_W-1:0]  realign_cnt_r, realign_cnt_s;
  logic [WORD_W-1:0] data_word_r, data_word_s;
  logic              word_valid_r, word_valid_s;
  logic              sdr_clk_r, sdr_clk_s;
  logic              locked_r, locked_s;
  logic [WORD_W-1:0] sr_next_s;
  logic              match_s, boundary_s, fail_s, stay_locked_s;

  align_pattern_det #(.WORD_W(WORD_W), .TP(TP)) u_det (
    .CLK_IN      (CLK_IN),
    .Test_N      (Test_N),
    .serial_data (serial_data),
    .sr_next     (sr_next_s),
    .match       (match_s)
  );

  assign boundary_s = (bit_cnt_r == BIT_LAST);

  // Next state and alignment counters; retrain overrides every transition.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = boundary_s ? '0 : bit_cnt_r + BC_W'(1);
    match_cnt_s = match_cnt_r;
    err_cnt_s   = err_cnt_r;
    fail_s      = 1'b0;
    if (retrain) begin
      state_s     = ST_SEARCH;
      bit_cnt_s   = '0;
      match_cnt_s = '0;
      err_cnt_s   = '0;
    end else begin
      case (state_r)
        ST_SEARCH: begin
          if (match_s) begin
            bit_cnt_s   = '0;
            match_cnt_s = MC_W'(1);
            err_cnt_s   = '0;
            state_s     = (LOCK_CNT == 1) ? ST_LOCKED : ST_CONFIRM;
          end else begin
            state_s = ST_SEARCH;
          end
        end
        ST_CONFIRM: begin
          if (boundary_s && match_s) begin
            match_cnt_s = match_cnt_r + MC_W'(1);
            state_s     = (match_cnt_s == LOCK_LIM) ? ST_LOCKED : ST_CONFIRM;
          end else if (boundary_s) begin
            match_cnt_s = '0;
            fail_s      = 1'b1;
            state_s     = ST_SEARCH;
          end else begin
            state_s = ST_CONFIRM;
          end
        end
        ST_LOCKED: begin
          if (boundary_s && train_en && !match_s) begin
            err_cnt_s = err_cnt_r + EC_W'(1);
            if (err_cnt_s == LOSS_LIM) begin
              err_cnt_s = '0;
              fail_s    = 1'b1;
              state_s   = ST_SEARCH;
            end else begin
              state_s = ST_LOCKED;
            end
          end else if (boundary_s && train_en) begin
            err_cnt_s = '0;
          end else begin
            state_s = ST_LOCKED;
          end
        end
        default: begin
          state_s = ST_SEARCH;
        end
      endcase
    end
  end

  // Output next-values; words are only presented while lock is held across the edge.
  always_comb begin
    stay_locked_s = (state_r == ST_LOCKED) && (state_s == ST_LOCKED);
    word_valid_s  = stay_locked_s && boundary_s;
    data_word_s   = word_valid_s ? sr_next_s : data_word_r;
    locked_s      = (state_s == ST_LOCKED);
    if (fail_s && (realign_cnt_r != {CNT_W{1'b1}})) begin
      realign_cnt_s = realign_cnt_r + CNT_W'(1);
    end else begin
      realign_cnt_s = realign_cnt_r;
    end
    if (!stay_locked_s) begin
      sdr_clk_s = 1'b0;
    end else if (boundary_s) begin
      sdr_clk_s = 1'b1;
    end else if (bit_cnt_r == BIT_HALF) begin
      sdr_clk_s = 1'b0;
    end else begin
      sdr_clk_s = sdr_clk_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK_IN or negedge Test_N) begin
    if (!Test_N) begin
      state_r       <= ST_SEARCH;
      bit_cnt_r     <= '0;
      match_cnt_r   <= '0;
      err_cnt_r     <= '0;
      realign_cnt_r <= '0;
      data_word_r   <= '0;
      word_valid_r  <= 1'b0;
      sdr_clk_r     <= 1'b0;
      locked_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      bit_cnt_r     <= bit_cnt_s;
      match_cnt_r   <= match_cnt_s;
      err_cnt_r     <= err_cnt_s;
      realign_cnt_r <= realign_cnt_s;
      data_word_r   <= data_word_s;
      word_valid_r  <= word_valid_s;
      sdr_clk_r     <= sdr_clk_s;
      locked_r      <= locked_s;
    end
  end

  assign data_word   = data_word_r;
  assign word_valid  = word_valid_r;
  assign SDR_CLK     = sdr_clk_r;
  assign locked      = locked_r;
  assign realign_cnt = realign_cnt_r;

endmodule
